rf_write_arbiter: RTL

//  Shares the single register-file write port between the in-order writeback path (pipe) and load returns from memory (mem).

---
 rtl/rf_wr_pkg.sv | 20 ++
 rtl/rf_wr_queue.sv | 59 +++++
 rtl/rf_write_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rf_wr_pkg.sv
// Shared types for the register-file write-port arbiter: queue entry layout,
// grant encoding and the hard-wired x0 index.
package rf_wr_pkg;

    localparam logic [4:0] RF_X0 = 5'd0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        killed;
    } rf_wr_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PIPE,
        GRANT_QUEUE,
        GRANT_BYPASS
    } e_rf_wr_grant;

endpackage

// File: rtl/rf_wr_queue.sv
// Circular FIFO of pending load results. Every entry compares its rd against
// kill_rd in parallel so a younger pipe write can mark stale loads dead.
import rf_wr_pkg::*;

module rf_wr_queue #(
    parameter int Q_DEPTH = 4,
    localparam int PW = $clog2(Q_DEPTH),
    localparam int CW = $clog2(Q_DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  rf_wr_entry_t push_entry,
    input  logic         pop,
    input  logic         kill_valid,
    input  logic [4:0]   kill_rd,
    output rf_wr_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    rf_wr_entry_t   slots [Q_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    assign head  = slots[rd_ptr];
    assign full  = (count == CW'(Q_DEPTH));
    assign empty = (count == '0);

    // Storage carries no reset; only the pointers and count define liveness.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Q_DEPTH; i++) begin
            if (kill_valid && slots[i].rd == kill_rd)
                slots[i].killed <= 1'b1;
        end
        if (push)
            slots[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single regfile write port between writeback (priority) and
// queued load returns, with WAW kill and a starvation stall.
// Optional same-cycle load bypass when RF_WR_BYPASS_EN is defined.
import rf_wr_pkg::*;

module rf_write_arbiter #(
    parameter int Q_DEPTH      = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int CW = $clog2(Q_DEPTH + 1),
    localparam int WW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_wr_valid,
    input  logic [4:0]    pipe_wr_rd,
    input  logic [31:0]   pipe_wr_data,
    output logic          pipe_stall,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_rd,
    input  logic [31:0]   mem_data,
    output logic          rf_write_enable,
    output logic [4:0]    rf_write_reg,
    output logic [31:0]   rf_write_value,
    output logic [CW-1:0] q_count
);

    e_rf_wr_grant  grant;
    rf_wr_entry_t  q_head;
    rf_wr_entry_t  push_entry;
    logic          q_full, q_empty;
    logic          push, pop, kill_valid, bypass;
    logic          head_live, head_dead, pipe_req;
    logic          stall_q;
    logic [WW-1:0] wait_cnt;

    assign head_live  = !q_empty && !q_head.killed && (q_head.rd != RF_X0);
    assign head_dead  = !q_empty && !head_live;
    assign pipe_req   = pipe_wr_valid && (pipe_wr_rd != RF_X0);
    assign pipe_stall = stall_q;
    assign mem_ready  = rst_n && !q_full;

    always_comb begin
        grant      = GRANT_NONE;
        pop        = 1'b0;
        kill_valid = 1'b0;
        bypass     = 1'b0;
        if (rst_n) begin
            if (stall_q) begin
                pop = !q_empty;
                if (head_live) grant = GRANT_QUEUE;
            end else if (pipe_req) begin
                grant      = GRANT_PIPE;
                kill_valid = 1'b1;
                pop        = head_dead;
            end else if (!q_empty) begin
                pop = 1'b1;
                if (head_live) grant = GRANT_QUEUE;
            end
`ifdef RF_WR_BYPASS_EN
            else if (mem_valid) begin
                bypass = 1'b1;
                if (mem_rd != RF_X0) grant = GRANT_BYPASS;
            end
`endif
        end
    end

    // A load accepted alongside a same-rd pipe write is older, so it lands dead.
    assign push       = mem_valid && mem_ready && !bypass;
    assign push_entry = '{rd: mem_rd, data: mem_data,
                          killed: kill_valid && (mem_rd == pipe_wr_rd)};

    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_reg    = RF_X0;
        rf_write_value  = '0;
        case (grant)
            GRANT_PIPE: begin
                rf_write_enable = 1'b1;
                rf_write_reg    = pipe_wr_rd;
                rf_write_value  = pipe_wr_data;
            end
            GRANT_QUEUE: begin
                rf_write_enable = 1'b1;
                rf_write_reg    = q_head.rd;
                rf_write_value  = q_head.data;
            end
            GRANT_BYPASS: begin
                rf_write_enable = 1'b1;
                rf_write_reg    = mem_rd;
                rf_write_value  = mem_data;
            end
            default: ;
        endcase
    end

    // Stall is scheduled only while a live head is waiting, so the stall cycle
    // always finds a non-empty queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            if (head_live && !pop) begin
                if (wait_cnt == WW'(STARVE_LIMIT - 1)) begin
                    stall_q  <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    rf_wr_queue #(.Q_DEPTH(Q_DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_valid (kill_valid),
        .kill_rd    (pipe_wr_rd),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

endmodule
